// File: rtl/rob_commit_scheduler.sv
// rtl/rob_commit_scheduler.sv - reorder-buffer dispatch/completion/commit sequencer with violation flush
//
// Purpose:
//   Hands out ROB indices to up to two dispatches per cycle, records writeback
//   completion per entry, and retires up to two completed entries per cycle in
//   program order from the head. An accepted memory-order violation squashes the
//   violating entry and everything younger, then holds dispatch and commit for
//   FLUSH_CYCLES cycles.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   dispatch_req_1/2                  dispatch requests (1 = older instruction)
//   dispatch_grant_1/2                combinational grants
//   dispatch_idx_1/2                  indices offered to the two dispatch slots
//   complete_valid_1/2, complete_idx_1/2   writeback completion strobes
//   violation_detected, violation_idx      memory-order violation report
//   commit_valid_1/2, commit_idx_1/2       registered in-order commit strobes
//   flush_busy                        high while the flush window is active
//   rob_full, rob_empty               occupancy flags
//   perf_commit_cnt, perf_flush_cnt   only with ROB_PERF_CNT_EN defined
//
// Optional build macro: ROB_PERF_CNT_EN adds the two wrapping 32-bit perf counters.

module rob_commit_scheduler #(
  parameter int ROB_NUM      = 16,
  parameter int ROB_SEL      = 4,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dispatch_req_1,
  input  logic               dispatch_req_2,
  output logic               dispatch_grant_1,
  output logic               dispatch_grant_2,
  output logic [ROB_SEL-1:0] dispatch_idx_1,
  output logic [ROB_SEL-1:0] dispatch_idx_2,
  input  logic               complete_valid_1,
  input  logic [ROB_SEL-1:0] complete_idx_1,
  input  logic               complete_valid_2,
  input  logic [ROB_SEL-1:0] complete_idx_2,
  input  logic               violation_detected,
  input  logic [ROB_SEL-1:0] violation_idx,
  output logic               commit_valid_1,
  output logic [ROB_SEL-1:0] commit_idx_1,
  output logic               commit_valid_2,
  output logic [ROB_SEL-1:0] commit_idx_2,
  output logic               flush_busy,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]        perf_commit_cnt,
  output logic [31:0]        perf_flush_cnt,
`endif
  output logic               rob_full,
  output logic               rob_empty
);

  localparam int CW   = ROB_SEL + 1;
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [CW-1:0]      CNT_TWO = CW'(2);
  localparam logic [CW-1:0]      CNT_MAX = CW'(ROB_NUM);
  localparam logic [ROB_SEL-1:0] IDX_ONE = ROB_SEL'(1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic [ROB_SEL-1:0]  head_q, head_d;
  logic [ROB_SEL-1:0]  tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [ROB_NUM-1:0]  valid_q, valid_d;
  logic [ROB_NUM-1:0]  done_q, done_d;
  logic                cv1_q, cv1_d, cv2_q, cv2_d;
  logic [ROB_SEL-1:0]  ci1_q, ci1_d, ci2_q, ci2_d;

  logic                in_run, viol_ok;
  logic                grant_1, grant_2, c1, c2;
  logic [ROB_SEL-1:0]  head_p1, idx_2, viol_off;
  logic [CW-1:0]       free;

  // Decisions for this cycle. An accepted violation suppresses both dispatch
  // and commit so nothing enters or leaves the ROB while it is being cut back.
  always_comb begin
    in_run   = (state_q == ST_RUN);
    viol_ok  = in_run && violation_detected && valid_q[violation_idx];
    free     = CNT_MAX - count_q;
    head_p1  = head_q + IDX_ONE;
    idx_2    = tail_q + ROB_SEL'(dispatch_req_1);
    viol_off = violation_idx - head_q;
    grant_1  = in_run && !viol_ok && dispatch_req_1 && (free >= CNT_ONE);
    grant_2  = in_run && !viol_ok && dispatch_req_2 &&
               (free >= (dispatch_req_1 ? CNT_TWO : CNT_ONE));
    c1       = in_run && !viol_ok && (count_q >= CNT_ONE) && done_q[head_q];
    c2       = c1 && (count_q >= CNT_TWO) && done_q[head_p1];
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    cv1_d   = c1;
    cv2_d   = c2;
    ci1_d   = c1 ? head_q  : '0;
    ci2_d   = c2 ? head_p1 : '0;

    // Completions only land on live entries; stale writebacks are dropped.
    if (complete_valid_1 && valid_q[complete_idx_1]) done_d[complete_idx_1] = 1'b1;
    if (complete_valid_2 && valid_q[complete_idx_2]) done_d[complete_idx_2] = 1'b1;

    if (viol_ok) begin
      // Age is distance from head; everything at least as young as the
      // violating entry is squashed. Slots outside the live window are
      // already clear, so clearing them again is harmless.
      for (int i = 0; i < ROB_NUM; i++) begin
        if ((ROB_SEL'(i) - head_q) >= viol_off) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      tail_d  = violation_idx;
      count_d = {1'b0, viol_off};
      state_d = ST_FLUSH;
      fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
    end else if (in_run) begin
      if (c1) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
      end
      if (c2) begin
        valid_d[head_p1] = 1'b0;
        done_d[head_p1]  = 1'b0;
      end
      if (grant_1) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
      end
      if (grant_2) begin
        valid_d[idx_2] = 1'b1;
        done_d[idx_2]  = 1'b0;
      end
      head_d  = head_q + ROB_SEL'(c1) + ROB_SEL'(c2);
      tail_d  = tail_q + ROB_SEL'(grant_1) + ROB_SEL'(grant_2);
      count_d = count_q + CW'(grant_1) + CW'(grant_2) - CW'(c1) - CW'(c2);
    end else begin
      // Counter was loaded with FLUSH_CYCLES-1 on entry, so FLUSH lasts
      // exactly FLUSH_CYCLES cycles.
      if (fcnt_q == '0) state_d = ST_RUN;
      else              fcnt_d  = fcnt_q - FC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      cv1_q   <= 1'b0;
      cv2_q   <= 1'b0;
      ci1_q   <= '0;
      ci2_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cv1_q   <= cv1_d;
      cv2_q   <= cv2_d;
      ci1_q   <= ci1_d;
      ci2_q   <= ci2_d;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt_q, perf_commit_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_commit_cnt_d = perf_commit_cnt_q + 32'(c1) + 32'(c2);
    perf_flush_cnt_d  = perf_flush_cnt_q + 32'(viol_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_commit_cnt_q <= '0;
      perf_flush_cnt_q  <= '0;
    end else begin
      perf_commit_cnt_q <= perf_commit_cnt_d;
      perf_flush_cnt_q  <= perf_flush_cnt_d;
    end
  end

  assign perf_commit_cnt = perf_commit_cnt_q;
  assign perf_flush_cnt  = perf_flush_cnt_q;
`endif

  assign dispatch_grant_1 = grant_1;
  assign dispatch_grant_2 = grant_2;
  assign dispatch_idx_1   = tail_q;
  assign dispatch_idx_2   = idx_2;
  assign commit_valid_1   = cv1_q;
  assign commit_valid_2   = cv2_q;
  assign commit_idx_1     = ci1_q;
  assign commit_idx_2     = ci2_q;
  assign flush_busy       = (state_q == ST_FLUSH);
  assign rob_full         = (count_q == CNT_MAX);
  assign rob_empty        = (count_q == '0);

endmodule
